cla4_driver: RTL and testbench
==============================

# cla4_driver

Issue/collect controller for the registered 4-bit CLA adder stage in the MAC_512 datapath. Accepts operand pairs on a valid/ready stream and drives the adder's `en`/`A_in`/`B_in` inputs. Tracks each operation through the adder's two register stages and captures `res` into a result FIFO presented on a valid/ready stream. Checks every adder result against an internally computed mod-16 sum and reports mismatches.

## Interface
- `DEPTH`, 4: result FIFO depth. Power of 2, ≥ 2. DEPTH ≥ 4 is required for one op/cycle throughput.
- `CNT_W`, 16: width of the op and error counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset. Integration ties the adder's `rst_n` to `~rst`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted when `in_valid && in_ready` (in_fire).
- `in_a`  in  4  operand A.
- `in_b`  in  4  operand B.
- `add_en`  out  1  to adder `en`.
- `add_a`  out  4  to adder `A_in`.
- `add_b`  out  4  to adder `B_in`.
- `add_res`  in  4  from adder `res`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head when `out_valid && out_ready` (out_fire).
- `out_sum`  out  4  FIFO head. Reads 0 when `out_valid` = 0.
- `err`  out  1  sticky mismatch flag.
- `err_count`  out  CNT_W  mismatches, saturating.
- `op_count`  out  CNT_W  results pushed into FIFO, wraps mod 2^CNT_W.

## Operation
- Shadow pipeline mirrors the adder. Stage 1 holds `v1` and `e1`; stage 2 holds `v2` and `e2`. The expected value is `(in_a + in_b) mod 16` (adder carry-out is unused).
- `add_en = in_fire | v1 | v2`. The adder clocks only while work is in flight or entering, and holds when idle.
- `add_a`/`add_b` = `in_a`/`in_b` when in_fire, else 0. Bubbles enter as `v1` = 0.
- On each edge with `add_en` = 1:
  - `v1 <= in_fire`, `e1 <=` expected.
  - `v2 <= v1`, `e2 <= e1`.
- With `add_en` = 0: shadow state holds. `v1` = `v2` = 0 in this case, so nothing is lost.
- When `v2` = 1: push `add_res` into the FIFO and increment `op_count`. If `add_res != e2`, set `err` and increment `err_count`, saturating at all-ones. The hardware value is pushed, not the expected value.
- Credit flow control: `in_ready = !rst && (fifo_count + v1 + v2 < DEPTH)`.
  - A pop in the same cycle is not credited; this keeps the path registered-only.
  - The credit guarantees the FIFO never overflows. The push path has no stall.
- FIFO: circular, read/write pointers wrap modulo DEPTH. Simultaneous push and pop leaves occupancy unchanged and is legal when full or empty. A push into an empty FIFO becomes visible the next cycle (no bypass).
- `err` clears only on `rst`.

## Timing
- in_fire in cycle t:
  - Adder input regs hold the pair in t+1.
  - `add_res` is valid in t+2 (`v2` = 1, checked and pushed at end of t+2).
  - `out_valid` is asserted in t+3 if the FIFO was otherwise empty.
- Latency is 3 cycles in to out.
- With `out_ready` held at 1 and DEPTH = 4, steady-state occupancy is ≤ 3 (1 + v1 + v2), so `in_ready` stays 1 and throughput is 1 op/cycle.
- With `out_ready` = 0: at most DEPTH ops are accepted, then `in_ready` drops. In-flight ops still drain into the FIFO.
- Reset values, in the cycle after `rst` is sampled high and while it is held:
  - `in_ready` 0, `out_valid` 0, `out_sum` 0
  - `add_en` 0, `add_a` 0, `add_b` 0
  - `err` 0, `err_count` 0, `op_count` 0
  - `v1`, `v2`, FIFO pointers and occupancy all 0
- `in_ready` = 1 in the first cycle after `rst` deasserts.
- Reset mid-operation discards all in-flight and buffered results with no push, pop or count update.
- Every output is either a register or a simple AND/mux of registers and inputs. There is no combinational path from `out_ready` to `in_ready`.

## Test plan
- Single op: `rst` pulse, then in_fire with a=3, b=5 in cycle 10, `out_ready` = 1 → `add_en` = 1 in cycles 10–12; `out_valid` = 1 with `out_sum` = 8 in cycle 13 only; `op_count` = 1; `err` = 0.
- Wrap: a=9, b=9 → `out_sum` = 2. a=15, b=15 → 14. No error flagged.
- Streaming: 16 back-to-back pairs (a=i, b=2i) with `out_ready` = 1 → `in_ready` never drops; outputs appear in order in consecutive cycles; last output arrives 3 cycles after the last input; `op_count` = 16.
- Backpressure: `out_ready` = 0, `in_valid` held 1 with DEPTH = 4 → exactly 4 accepted, then `in_ready` = 0. Then `out_ready` = 1 → 4 results pop in order, and `in_ready` returns to 1 the cycle after the first pop.
- Fault injection: force `add_res` = 0 in the cycle an op a=1, b=1 reaches stage 2 → `err` = 1 and `err_count` = 1 next cycle; `out_sum` = 0 is delivered; `err` stays set through later good ops.
- Reset mid-flight: accept 3 ops, assert `rst` while `v1` = `v2` = 1 and the FIFO holds 1 entry → all outputs return to reset values; no `out_valid` pulse afterwards; the next op after reset returns the correct sum at latency 3.

Source files
------------

// File: rtl/cla4_driver.sv
// Issue/collect controller for the registered 4-bit CLA adder stage.
// Operands enter on a valid/ready stream and are launched into the adder.
// A two-stage shadow pipeline tracks each operation and its expected mod-16
// sum. Adder results are buffered in a small circular FIFO and presented on
// an output valid/ready stream. Mismatches against the expected sum are
// flagged and counted.
module cla4_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             add_en,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    input  logic [3:0]       add_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    // Shadow pipeline mirroring the adder's two register stages.
    logic             r_v1;
    logic             r_v2;
    logic [3:0]       r_e1;
    logic [3:0]       r_e2;

    // Result FIFO storage and bookkeeping.
    logic [3:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Status registers.
    logic             r_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_op_count;

    logic             w_in_fire;
    logic             w_add_en;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;
    logic             w_mismatch;
    logic [3:0]       w_expected;
    logic [CW:0]      w_inflight;

    // Credit counts everything already committed to land in the FIFO:
    // buffered entries plus both in-flight stages. Pops in the same cycle
    // are deliberately not credited so out_ready never reaches in_ready.
    assign w_inflight  = {1'b0, r_count} + {{CW{1'b0}}, r_v1} + {{CW{1'b0}}, r_v2};
    assign in_ready    = !rst && (w_inflight < DEPTH_L);
    assign w_in_fire   = in_valid && in_ready;
    assign w_expected  = in_a + in_b;

    // Adder only clocks while something is entering or in flight.
    assign w_add_en    = w_in_fire | r_v1 | r_v2;
    assign add_en      = w_add_en;
    assign add_a       = w_in_fire ? in_a : 4'd0;
    assign add_b       = w_in_fire ? in_b : 4'd0;

    assign w_out_valid = (r_count != '0);
    assign w_push      = r_v2;
    assign w_pop       = w_out_valid && out_ready;
    assign w_mismatch  = r_v2 && (add_res != r_e2);

    assign out_valid   = w_out_valid;
    assign out_sum     = w_out_valid ? r_mem[r_rd_ptr] : 4'd0;
    assign err         = r_err;
    assign err_count   = r_err_count;
    assign op_count    = r_op_count;

    // Advance the shadow pipeline in lockstep with the adder's enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_e1 <= 4'd0;
            r_e2 <= 4'd0;
        end else if (w_add_en) begin
            r_v1 <= w_in_fire;
            r_e1 <= w_in_fire ? w_expected : 4'd0;
            r_v2 <= r_v1;
            r_e2 <= r_e1;
        end
    end

    // FIFO storage write; contents need no reset since out_sum is gated.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= add_res;
        end
    end

    // FIFO pointers and occupancy; push never stalls thanks to the credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result checking: sticky error flag, saturating error and wrapping op counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_push) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla4_driver.sv
// Self-checking bench for cla4_driver. A behavioural two-stage adder model
// sits on the add_* port; expected sums go into a scoreboard queue when an
// operand pair is accepted and are compared when the DUT delivers a result.
module tb_cla4_driver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic        add_en;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_res;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sum;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] op_count;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [3:0] exp_q[$];
    int         out_cyc_q[$];
    logic [3:0] mon_exp;

    // Adder model: input registers then result register, both gated by en.
    logic [3:0] m_ra;
    logic [3:0] m_rb;
    logic [3:0] m_res;
    logic       force_zero;

    cla4_driver #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_res   (add_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .err       (err),
        .err_count (err_count),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_ra  <= 4'd0;
            m_rb  <= 4'd0;
            m_res <= 4'd0;
        end else if (add_en) begin
            m_ra  <= add_a;
            m_rb  <= add_b;
            m_res <= m_ra + m_rb;
        end
    end

    assign add_res = force_zero ? 4'd0 : m_res;

    // Scoreboard: every delivered result is compared to the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected cyc=%0d got=%0d required=none", cyc, out_sum);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_sum !== mon_exp)
                    $display("FAIL out_sum cyc=%0d got=%0d required=%0d", cyc, out_sum, mon_exp);
                else begin
                    passed++;
                    $display("out  cyc=%0d sum=%0d", cyc, out_sum);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair, wait (bounded) for acceptance, record the fire cycle.
    task automatic drive_op(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] exp_sum, output int fire_cyc);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            step();
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL accept_timeout a=%0d b=%0d got=in_ready 0 required=1", a, b);
        end else begin
            passed++;
            exp_q.push_back(exp_sum);
            $display("in   cyc=%0d a=%0d b=%0d exp=%0d", cyc, a, b, exp_sum);
        end
        fire_cyc = cyc;
        step();
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            step();
            budget++;
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
        else
            passed++;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        out_ready = 1'b0; force_zero = 1'b0;
        step();
        step();
        @(negedge clk);
        checks += 9;
        if (in_ready  !== 1'b0) $display("FAIL rst_in_ready got=%0b required=0", in_ready);   else passed++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b required=0", out_valid); else passed++;
        if (out_sum   !== 4'd0) $display("FAIL rst_out_sum got=%0d required=0", out_sum);     else passed++;
        if (add_en    !== 1'b0) $display("FAIL rst_add_en got=%0b required=0", add_en);       else passed++;
        if (add_a     !== 4'd0) $display("FAIL rst_add_a got=%0d required=0", add_a);         else passed++;
        if (add_b     !== 4'd0) $display("FAIL rst_add_b got=%0d required=0", add_b);         else passed++;
        if (err       !== 1'b0) $display("FAIL rst_err got=%0b required=0", err);             else passed++;
        if (err_count !== 16'd0) $display("FAIL rst_err_count got=%0d required=0", err_count); else passed++;
        if (op_count  !== 16'd0) $display("FAIL rst_op_count got=%0d required=0", op_count);  else passed++;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%0b required=1", in_ready); else passed++;
        $display("reset checked cyc=%0d", cyc);
        step();
    endtask

    task automatic test_single_op();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b1) $display("FAIL single_in_ready got=%0b required=1", in_ready); else passed++;
        if (add_en   !== 1'b1) $display("FAIL single_add_en0 got=%0b required=1", add_en);    else passed++;
        if (add_a    !== 4'd3) $display("FAIL single_add_a got=%0d required=3", add_a);       else passed++;
        if (add_b    !== 4'd5) $display("FAIL single_add_b got=%0d required=5", add_b);       else passed++;
        exp_q.push_back(4'd8);
        $display("in   cyc=%0d a=3 b=5 exp=8", cyc);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks += 2;
            if (add_en !== (k <= 2))
                $display("FAIL single_add_en k=%0d got=%0b required=%0b", k, add_en, (k <= 2));
            else passed++;
            if (out_valid !== (k == 3))
                $display("FAIL single_out_valid k=%0d got=%0b required=%0b", k, out_valid, (k == 3));
            else passed++;
            step();
        end
        checks += 2;
        if (op_count !== 16'd1) $display("FAIL single_op_count got=%0d required=1", op_count); else passed++;
        if (err !== 1'b0) $display("FAIL single_err got=%0b required=0", err); else passed++;
    endtask

    task automatic test_wrap();
        int fc;
        out_ready = 1'b1;
        drive_op(4'd9, 4'd9, 4'd2, fc);
        drive_op(4'd15, 4'd15, 4'd14, fc);
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (err !== 1'b0) $display("FAIL wrap_err got=%0b required=0", err); else passed++;
    endtask

    task automatic test_back_to_back();
        int first_cyc, fc, stalls;
        logic [15:0] ob;
        logic [3:0]  a, b, e;
        ob = op_count;
        stalls = 0;
        first_cyc = 0;
        out_ready = 1'b1;
        out_cyc_q.delete();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            b = 4'(2 * i);
            e = 4'((3 * i) % 16);
            drive_op(a, b, e, fc);
            if (i == 0) first_cyc = fc;
            else if (fc != first_cyc + i) stalls++;
        end
        in_valid = 1'b0;
        wait_drain();
        checks += 4;
        if (stalls != 0) $display("FAIL stream_in_ready_drop got=%0d stalls required=0", stalls); else passed++;
        if (out_cyc_q.size() != 16)
            $display("FAIL stream_out_count got=%0d required=16", out_cyc_q.size());
        else passed++;
        if (out_cyc_q.size() == 16 && out_cyc_q[15] == fc + 3 && out_cyc_q[0] == first_cyc + 3)
            passed++;
        else
            $display("FAIL stream_latency got_last=%0d required=%0d", (out_cyc_q.size() > 0) ? out_cyc_q[out_cyc_q.size()-1] : -1, fc + 3);
        if (op_count !== ob + 16'd16) $display("FAIL stream_op_count got=%0d required=%0d", op_count, ob + 16'd16); else passed++;
    endtask

    task automatic test_backpressure();
        int accepted;
        logic [15:0] ob;
        logic [3:0]  a;
        ob = op_count;
        accepted = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            a = 4'(k + 4);
            in_valid = 1'b1; in_a = a; in_b = 4'd1;
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                exp_q.push_back(a + 4'd1);
                $display("in   cyc=%0d a=%0d b=1 exp=%0d", cyc, a, a + 4'd1);
            end
            step();
        end
        @(negedge clk);
        checks += 2;
        if (accepted != 4) $display("FAIL bp_accepted got=%0d required=4", accepted); else passed++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%0b required=0", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) $display("FAIL bp_first_pop got=%0b required=1", out_valid); else passed++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_pop_cycle got=%0b required=0", in_ready); else passed++;
        step();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after_pop got=%0b required=1", in_ready); else passed++;
        wait_drain();
        checks++;
        if (op_count !== ob + 16'd4) $display("FAIL bp_op_count got=%0d required=%0d", op_count, ob + 16'd4); else passed++;
    endtask

    task automatic test_fault();
        int fc;
        out_ready = 1'b1;
        checks++;
        if (err !== 1'b0) $display("FAIL fault_pre_err got=%0b required=0", err); else passed++;
        drive_op(4'd1, 4'd1, 4'd0, fc);
        in_valid = 1'b0;
        step();
        force_zero = 1'b1;
        step();
        force_zero = 1'b0;
        @(negedge clk);
        checks += 2;
        if (err !== 1'b1) $display("FAIL fault_err got=%0b required=1", err); else passed++;
        if (err_count !== 16'd1) $display("FAIL fault_err_count got=%0d required=1", err_count); else passed++;
        step();
        drive_op(4'd2, 4'd3, 4'd5, fc);
        drive_op(4'd6, 4'd6, 4'd12, fc);
        in_valid = 1'b0;
        wait_drain();
        checks += 2;
        if (err !== 1'b1) $display("FAIL fault_err_sticky got=%0b required=1", err); else passed++;
        if (err_count !== 16'd1) $display("FAIL fault_err_count_hold got=%0d required=1", err_count); else passed++;
    endtask

    task automatic test_reset_midflight();
        int fc;
        out_ready = 1'b0;
        drive_op(4'd1, 4'd2, 4'd3, fc);
        drive_op(4'd4, 4'd4, 4'd8, fc);
        drive_op(4'd5, 4'd6, 4'd11, fc);
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) $display("FAIL mid_fifo_one got=%0b required=1", out_valid); else passed++;
        if (add_en !== 1'b1) $display("FAIL mid_inflight got=%0b required=1", add_en); else passed++;
        rst = 1'b1;
        exp_q.delete();
        step();
        @(negedge clk);
        checks += 7;
        if (in_ready  !== 1'b0)  $display("FAIL mid_rst_in_ready got=%0b required=0", in_ready);    else passed++;
        if (out_valid !== 1'b0)  $display("FAIL mid_rst_out_valid got=%0b required=0", out_valid);  else passed++;
        if (out_sum   !== 4'd0)  $display("FAIL mid_rst_out_sum got=%0d required=0", out_sum);      else passed++;
        if (add_en    !== 1'b0)  $display("FAIL mid_rst_add_en got=%0b required=0", add_en);        else passed++;
        if (op_count  !== 16'd0) $display("FAIL mid_rst_op_count got=%0d required=0", op_count);    else passed++;
        if (err       !== 1'b0)  $display("FAIL mid_rst_err got=%0b required=0", err);              else passed++;
        if (err_count !== 16'd0) $display("FAIL mid_rst_err_count got=%0d required=0", err_count);  else passed++;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) $display("FAIL mid_no_pulse k=%0d got=%0b required=0", k, out_valid); else passed++;
            step();
        end
        out_cyc_q.delete();
        drive_op(4'd7, 4'd8, 4'd15, fc);
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (out_cyc_q.size() == 1 && out_cyc_q[0] == fc + 3)
            passed++;
        else
            $display("FAIL mid_post_latency got=%0d required=%0d", (out_cyc_q.size() > 0) ? out_cyc_q[0] : -1, fc + 3);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_fault();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue got=%0d required=0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
